// File: rtl/sysid_pkg.sv
// sysid_pkg: shared types and constants for the system ID checker.
// Holds the FSM state type, sysid word addresses and default timestamp.
`timescale 1ns/1ps
package sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID_REQ,
      ST_ID_WAIT,
      ST_TS_REQ,
      ST_TS_WAIT,
      ST_FIN
   } sysid_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   // Build timestamp also baked into the sysid slave generator.
   localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1361531825;

endpackage

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that reads sysid words 0 and 1
// after reset or on start and latches a pass/fail verdict.
// Ports: clock, reset_n (async, active-low), start; avm_address, avm_read,
//   avm_readdata, avm_waitrequest, avm_readdatavalid; busy, done (pulse),
//   id_ok, ts_ok, pass, timed_out, id_value, ts_value (all registered).
// Macro SYSID_CHECKER_TIMEOUT_EN: adds a per-transaction timeout counter.
`timescale 1ns/1ps
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
   parameter int          AUTO_START     = 1,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic        timed_out,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   sysid_state_t r_state;
   logic         r_auto;
   logic         r_read;
   logic         r_addr;
   logic         r_busy;
   logic         r_done;
   logic         r_id_ok;
   logic         r_ts_ok;
   logic         r_pass;
   logic [31:0]  r_id_value;
   logic [31:0]  r_ts_value;
   logic         w_ts_match;

   assign w_ts_match = (avm_readdata == EXPECTED_TS);

`ifdef SYSID_CHECKER_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_to;
   logic        w_in_xfer;
   logic        w_expire;

   assign w_in_xfer = (r_state == ST_ID_REQ) || (r_state == ST_ID_WAIT) ||
                      (r_state == ST_TS_REQ) || (r_state == ST_TS_WAIT);
   // Fires on the cycle the counter would step up to the limit.
   assign w_expire  = w_in_xfer && (r_cnt == TIMEOUT_CYCLES - 16'd1);
   assign timed_out = r_to;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign timed_out        = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_auto     <= (AUTO_START != 0);
         r_read     <= 1'b0;
         r_addr     <= SYSID_ADDR_ID;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_pass     <= 1'b0;
         r_id_value <= '0;
         r_ts_value <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
         r_cnt      <= '0;
         r_to       <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
         if (w_in_xfer) r_cnt <= r_cnt + 16'd1;
`endif
         unique case (r_state)
            ST_IDLE: begin
               if (start || r_auto) begin
                  r_state <= ST_ID_REQ;
                  r_auto  <= 1'b0;
                  r_read  <= 1'b1;
                  r_addr  <= SYSID_ADDR_ID;
                  r_busy  <= 1'b1;
                  r_id_ok <= 1'b0;
                  r_ts_ok <= 1'b0;
                  r_pass  <= 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
                  r_cnt   <= '0;
                  r_to    <= 1'b0;
`endif
               end
            end
            ST_ID_REQ: begin
               if (!avm_waitrequest) begin
                  r_state <= ST_ID_WAIT;
                  r_read  <= 1'b0;
               end
            end
            ST_ID_WAIT: begin
               if (avm_readdatavalid) begin
                  r_state    <= ST_TS_REQ;
                  r_id_value <= avm_readdata;
                  r_id_ok    <= (avm_readdata == EXPECTED_ID);
                  r_read     <= 1'b1;
                  r_addr     <= SYSID_ADDR_TS;
`ifdef SYSID_CHECKER_TIMEOUT_EN
                  r_cnt      <= '0;
`endif
               end
            end
            ST_TS_REQ: begin
               if (!avm_waitrequest) begin
                  r_state <= ST_TS_WAIT;
                  r_read  <= 1'b0;
               end
            end
            ST_TS_WAIT: begin
               if (avm_readdatavalid) begin
                  r_state    <= ST_FIN;
                  r_ts_value <= avm_readdata;
                  r_ts_ok    <= w_ts_match;
                  // Verdict lands together with the done pulse.
                  r_pass     <= r_id_ok && w_ts_match;
                  r_done     <= 1'b1;
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_read  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
`ifdef SYSID_CHECKER_TIMEOUT_EN
         // Abandon the stuck transaction; the late flag wins over the case.
         if (w_expire) begin
            r_state <= ST_FIN;
            r_read  <= 1'b0;
            r_to    <= 1'b1;
            r_pass  <= 1'b0;
            r_done  <= 1'b1;
         end
`endif
      end
   end

   assign avm_address = r_addr;
   assign avm_read    = r_read;
   assign busy        = r_busy;
   assign done        = r_done;
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign pass        = r_pass;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;

endmodule
